// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one whole-line memory port between two cache controllers.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_rw,
  input  logic              r0_valid,
  output logic              r0_ready,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_rw,
  input  logic              r1_valid,
  output logic              r1_ready,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_dataout,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic [DATA_W-1:0] mem_req_datain,
  input  logic              mem_req_ready,
  output logic              busy,
  output logic              grant
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                grant_d, busy_d, sel;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                rw_d, valid_d;
  logic                r0_ready_d, r1_ready_d, r0_err_d, r1_err_d;
  logic [DATA_W-1:0]   r0_rdata_d, r1_rdata_d;
  logic                done, abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant;
    addr_d     = mem_req_addr;
    wdata_d    = mem_req_dataout;
    rw_d       = mem_req_rw;
    valid_d    = mem_req_valid;
    r0_ready_d = 1'b0;
    r1_ready_d = 1'b0;
    r0_err_d   = 1'b0;
    r1_err_d   = 1'b0;
    r0_rdata_d = '0;
    r1_rdata_d = '0;
    done       = 1'b0;
    abort      = 1'b0;
    // Lone requester wins; on a tie the one not served last wins
    sel        = r1_valid & (~r0_valid | ~last_q);
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (r0_valid || r1_valid) begin
          grant_d = sel;
          addr_d  = sel ? r1_addr  : r0_addr;
          wdata_d = sel ? r1_wdata : r0_wdata;
          rw_d    = sel ? r1_rw    : r0_rw;
          valid_d = 1'b1;
          state_d = ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUSY: begin
        done = mem_req_ready;
`ifdef MEM_ARB_TIMEOUT_EN
        // Memory completion on the limit edge still counts as a normal finish
        abort = ~mem_req_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if (!done && !abort) cnt_d = cnt_q + CNT_W'(1);
`endif
        if (done || abort) begin
          valid_d    = 1'b0;
          state_d    = ST_RESP;
          r0_ready_d = ~grant;
          r1_ready_d = grant;
          r0_err_d   = ~grant & abort;
          r1_err_d   = grant & abort;
          if (done && !mem_req_rw) begin
            if (grant) r1_rdata_d = mem_req_datain;
            else       r0_rdata_d = mem_req_datain;
          end
        end
      end
      ST_RESP: begin
        last_d  = grant;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      last_q          <= 1'b1;
      grant           <= 1'b1;
      busy            <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_dataout <= '0;
      mem_req_rw      <= 1'b0;
      mem_req_valid   <= 1'b0;
      r0_ready        <= 1'b0;
      r1_ready        <= 1'b0;
      r0_err          <= 1'b0;
      r1_err          <= 1'b0;
      r0_rdata        <= '0;
      r1_rdata        <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      grant           <= grant_d;
      busy            <= busy_d;
      mem_req_addr    <= addr_d;
      mem_req_dataout <= wdata_d;
      mem_req_rw      <= rw_d;
      mem_req_valid   <= valid_d;
      r0_ready        <= r0_ready_d;
      r1_ready        <= r1_ready_d;
      r0_err          <= r0_err_d;
      r1_err          <= r1_err_d;
      r0_rdata        <= r0_rdata_d;
      r1_rdata        <= r1_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model (round-robin order, line memory).
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] r0_addr, r1_addr, mem_req_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_req_dataout, mem_req_datain;
  logic          r0_rw, r1_rw, r0_valid, r1_valid, r0_ready, r1_ready, r0_err, r1_err;
  logic          mem_req_rw, mem_req_valid, mem_req_ready, busy, grant;

  int checks = 0;
  int failures = 0;

  // memory side: manual drive for directed tests, random-latency responder otherwise
  logic          mem_auto = 1'b0;
  logic          man_ready, auto_ready;
  logic [DW-1:0] man_data, auto_data;
  int            lat = -1;
  logic [DW-1:0] mem_store [logic [AW-1:0]];
  logic [DW-1:0] sb_mem    [logic [AW-1:0]];

  assign mem_req_ready  = mem_auto ? auto_ready : man_ready;
  assign mem_req_datain = mem_auto ? auto_data  : man_data;

  logic [1:0]    rdy_v, err_v;
  logic [DW-1:0] rd_v [2];
  assign rdy_v   = {r1_ready, r0_ready};
  assign err_v   = {r1_err, r0_err};
  assign rd_v[0] = r0_rdata;
  assign rd_v[1] = r1_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rw(r0_rw), .r0_valid(r0_valid),
    .r0_ready(r0_ready), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rw(r1_rw), .r1_valid(r1_valid),
    .r1_ready(r1_ready), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_req_addr(mem_req_addr), .mem_req_dataout(mem_req_dataout), .mem_req_rw(mem_req_rw),
    .mem_req_valid(mem_req_valid), .mem_req_datain(mem_req_datain), .mem_req_ready(mem_req_ready),
    .busy(busy), .grant(grant)
  );

  function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
    return {4{a ^ 32'hA5A5_0000}};
  endfunction

  // Random-latency memory; also raises spurious ready while no request is pending
  always @(negedge clk) begin
    if (mem_auto) begin
      if (!mem_req_valid) begin
        auto_ready = 1'($urandom_range(0, 1));
        auto_data  = {$urandom, $urandom, $urandom, $urandom};
        lat = -1;
      end else begin
        if (lat < 0) lat = $urandom_range(0, 4);
        if (lat == 0) begin
          auto_ready = 1'b1;
          if (mem_req_rw) begin
            auto_data = {$urandom, $urandom, $urandom, $urandom};
            mem_store[mem_req_addr] = mem_req_dataout;
          end else begin
            auto_data = mem_store.exists(mem_req_addr) ? mem_store[mem_req_addr] : init_line(mem_req_addr);
          end
        end else begin
          auto_ready = 1'b0;
        end
        lat--;
      end
    end
  end

  task automatic set_req(input int n, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rw);
    if (n == 0) begin r0_valid = v; r0_addr = a; r0_wdata = d; r0_rw = rw; end
    else        begin r1_valid = v; r1_addr = a; r1_wdata = d; r1_rw = rw; end
  endtask

  task automatic apply_reset();
    mem_auto  = 1'b0;
    man_ready = 1'b0;
    man_data  = '0;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    man_ready = 1'b0;
    man_data = '0;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if ({busy, mem_req_valid, mem_req_rw, r0_ready, r1_ready, r0_err, r1_err, grant} !== 8'b0000_0001) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000001", {busy, mem_req_valid, mem_req_rw, r0_ready, r1_ready, r0_err, r1_err, grant});
    end
    checks++;
    if ({mem_req_addr, mem_req_dataout, r0_rdata, r1_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%h dout=%h rd0=%h rd1=%h exp=0", mem_req_addr, mem_req_dataout, r0_rdata, r1_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 32'h0000_AB00, 128'h1111, 1'b0);
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_rw, grant, busy} !== {1'b1, 32'h0000_AB00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL read_req got v=%b a=%h rw=%b g=%b busy=%b exp v=1 a=0000ab00 rw=0 g=0 busy=1", mem_req_valid, mem_req_addr, mem_req_rw, grant, busy);
    end
    @(negedge clk);
    man_ready = 1'b1;
    man_data  = 128'h3344;
    @(negedge clk);
    checks++;
    if ({r0_ready, r0_rdata, r0_err, r1_ready, mem_req_valid} !== {1'b1, 128'h3344, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL read_resp got rdy0=%b rd0=%h err0=%b rdy1=%b v=%b exp rdy0=1 rd0=3344 err0=0 rdy1=0 v=0", r0_ready, r0_rdata, r0_err, r1_ready, mem_req_valid);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    man_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({r0_ready, r0_rdata, busy, mem_req_valid} !== {1'b0, 128'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL read_after got rdy0=%b rd0=%h busy=%b v=%b exp all 0", r0_ready, r0_rdata, busy, mem_req_valid);
    end
  endtask

  task automatic test_single_write();
    set_req(1, 1'b1, 32'h0000_EB00, 128'h5566, 1'b1);
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_rw, mem_req_dataout, grant} !== {1'b1, 32'h0000_EB00, 1'b1, 128'h5566, 1'b1}) begin
      failures++;
      $display("FAIL write_req got v=%b a=%h rw=%b d=%h g=%b exp v=1 a=0000eb00 rw=1 d=5566 g=1", mem_req_valid, mem_req_addr, mem_req_rw, mem_req_dataout, grant);
    end
    man_ready = 1'b1;
    man_data  = 128'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({r1_ready, r1_rdata, r1_err, r0_ready} !== {1'b1, 128'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL write_resp got rdy1=%b rd1=%h err1=%b rdy0=%b exp rdy1=1 rd1=0 err1=0 rdy0=0", r1_ready, r1_rdata, r1_err, r0_ready);
    end
    set_req(1, 1'b0, '0, '0, 1'b0);
    man_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [1:0] exp_order [4];
    exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
    apply_reset();
    set_req(0, 1'b1, 32'h0000_0100, 128'hA0, 1'b0);
    set_req(1, 1'b1, 32'h0000_0200, 128'hB1, 1'b0);
    man_ready = 1'b1;
    man_data  = 128'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid, grant} !== {1'b1, exp_order[i][0]}) begin
        failures++;
        $display("FAIL contention_grant%0d got v=%b g=%b exp v=1 g=%0d", i, mem_req_valid, grant, exp_order[i][0]);
      end
      @(negedge clk);
      checks++;
      if (rdy_v !== (2'b01 << exp_order[i])) begin
        failures++;
        $display("FAIL contention_ready%0d got=%b exp=%b", i, rdy_v, 2'b01 << exp_order[i]);
      end
      set_req(int'(exp_order[i]), 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      checks++;
      if ({mem_req_valid, rdy_v} !== 3'b000) begin
        failures++;
        $display("FAIL contention_gap%0d got v=%b rdy=%b exp 0", i, mem_req_valid, rdy_v);
      end
      set_req(int'(exp_order[i]), 1'b1, 32'h0000_0300, 128'hC2, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d, rd;
    logic [AW-1:0] a;
    apply_reset();
    a  = {$urandom_range(0, 255), 8'h00};
    d  = {$urandom, $urandom, $urandom, $urandom};
    rd = {$urandom, $urandom, $urandom, $urandom};
    set_req(0, 1'b1, a, d, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_rw, mem_req_dataout, rdy_v} !== {1'b1, a, 1'b1, d, 2'b00}) begin
        failures++;
        $display("FAIL backpressure_hold%0d got v=%b a=%h rw=%b rdy=%b exp v=1 a=%h rw=1 rdy=00", i, mem_req_valid, mem_req_addr, mem_req_rw, rdy_v, a);
      end
      @(negedge clk);
    end
    man_ready = 1'b1;
    man_data  = rd;
    @(negedge clk);
    checks++;
    if ({r0_ready, r0_rdata, r1_ready} !== {1'b1, 128'h0, 1'b0}) begin
      failures++;
      $display("FAIL backpressure_done got rdy0=%b rd0=%h rdy1=%b exp rdy0=1 rd0=0 rdy1=0", r0_ready, r0_rdata, r1_ready);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    man_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    logic [DW-1:0] rd;
    apply_reset();
    rd = {$urandom, $urandom, $urandom, $urandom};
    set_req(0, 1'b1, 32'h0000_4400, 128'h9, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, busy, r0_ready, r1_ready, grant} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_mid_busy got v=%b busy=%b rdy=%b%b g=%b exp v=0 busy=0 rdy=00 g=1", mem_req_valid, busy, r1_ready, r0_ready, grant);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 1'b1, 32'h0000_5500, 128'h0, 1'b0);
    @(negedge clk);
    checks++;
    if ({mem_req_valid, grant, mem_req_addr} !== {1'b1, 1'b1, 32'h0000_5500}) begin
      failures++;
      $display("FAIL reset_regrant got v=%b g=%b a=%h exp v=1 g=1 a=00005500", mem_req_valid, grant, mem_req_addr);
    end
    man_ready = 1'b1;
    man_data  = rd;
    @(negedge clk);
    checks++;
    if ({r1_ready, r1_rdata, r0_ready} !== {1'b1, rd, 1'b0}) begin
      failures++;
      $display("FAIL reset_resp got rdy1=%b rd1=%h rdy0=%b exp rdy1=1 rd1=%h rdy0=0", r1_ready, r1_rdata, r0_ready, rd);
    end
    set_req(1, 1'b0, '0, '0, 1'b0);
    man_ready = 1'b0;
    @(negedge clk);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic early;
    logic [DW-1:0] rd;
    apply_reset();
    set_req(0, 1'b1, 32'h0000_6600, 128'h1, 1'b0);
    @(negedge clk);
    early = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (r0_ready !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early got early_ready=%b exp=0", early);
    end
    @(negedge clk);
    checks++;
    if ({r0_ready, r0_err, r0_rdata, mem_req_valid} !== {1'b1, 1'b1, 128'h0, 1'b0}) begin
      failures++;
      $display("FAIL timeout_abort got rdy0=%b err0=%b rd0=%h v=%b exp rdy0=1 err0=1 rd0=0 v=0", r0_ready, r0_err, r0_rdata, mem_req_valid);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rd = {$urandom, $urandom, $urandom, $urandom};
    set_req(0, 1'b1, 32'h0000_6700, 128'h2, 1'b0);
    @(negedge clk);
    for (int i = 1; i < 8; i++) @(negedge clk);
    man_ready = 1'b1;
    man_data  = rd;
    @(negedge clk);
    checks++;
    if ({r0_ready, r0_err, r0_rdata} !== {1'b1, 1'b0, rd}) begin
      failures++;
      $display("FAIL timeout_priority got rdy0=%b err0=%b rd0=%h exp rdy0=1 err0=0 rd0=%h", r0_ready, r0_err, r0_rdata, rd);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    man_ready = 1'b0;
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    logic early;
    apply_reset();
    set_req(0, 1'b1, 32'h0000_6600, 128'h1, 1'b0);
    @(negedge clk);
    early = 1'b0;
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (r0_ready !== 1'b0) early = 1'b1;
    end
    checks++;
    if ({early, mem_req_valid, busy, r0_err} !== 4'b0110) begin
      failures++;
      $display("FAIL no_timeout got early=%b v=%b busy=%b err0=%b exp early=0 v=1 busy=1 err0=0", early, mem_req_valid, busy, r0_err);
    end
    man_ready = 1'b1;
    man_data  = 128'h55;
    @(negedge clk);
    checks++;
    if ({r0_ready, r0_rdata, r0_err} !== {1'b1, 128'h55, 1'b0}) begin
      failures++;
      $display("FAIL no_timeout_done got rdy0=%b rd0=%h err0=%b exp rdy0=1 rd0=55 err0=0", r0_ready, r0_rdata, r0_err);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    man_ready = 1'b0;
    @(negedge clk);
  endtask
`endif

  // Random traffic: model picks winner by round-robin rule and predicts line contents
  task automatic test_random();
    logic          pend [2];
    logic [AW-1:0] qa [2];
    logic [DW-1:0] qd [2];
    logic          qrw [2];
    logic [DW-1:0] exp_rd;
    logic          bad;
    int            last, w, cyc;
    apply_reset();
    mem_auto = 1'b1;
    last = 1;
    pend = '{1'b0, 1'b0};
    for (int t = 0; t < 60; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 2) != 0 || (n == 1 && !pend[0]))) begin
          pend[n] = 1'b1;
          qa[n]   = {20'h0, 4'($urandom_range(0, 7)), 8'h00};
          qd[n]   = {$urandom, $urandom, $urandom, $urandom};
          qrw[n]  = 1'($urandom_range(0, 1));
        end
      end
      set_req(0, pend[0], qa[0], qd[0], qrw[0]);
      set_req(1, pend[1], qa[1], qd[1], qrw[1]);
      w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
      @(negedge clk);
      checks++;
      if ({mem_req_valid, grant, mem_req_addr, mem_req_rw, mem_req_dataout} !== {1'b1, 1'(w), qa[w], qrw[w], qd[w]}) begin
        failures++;
        $display("FAIL rand_grant t=%0d got v=%b g=%b a=%h rw=%b exp v=1 g=%0d a=%h rw=%b", t, mem_req_valid, grant, mem_req_addr, mem_req_rw, w, qa[w], qrw[w]);
      end
      exp_rd = qrw[w] ? '0 : (sb_mem.exists(qa[w]) ? sb_mem[qa[w]] : init_line(qa[w]));
      cyc = 0;
      bad = 1'b0;
      while (rdy_v[w] !== 1'b1 && cyc < 50) begin
        if (rdy_v[1-w] !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== qa[w]) bad = 1'b1;
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (bad !== 1'b0 || rdy_v[w] !== 1'b1) begin
        failures++;
        $display("FAIL rand_wait t=%0d got hold_err=%b rdy=%b exp hold_err=0 rdy[%0d]=1", t, bad, rdy_v, w);
      end
      checks++;
      if ({rd_v[w], err_v[w], rdy_v[1-w], mem_req_valid} !== {exp_rd, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL rand_resp t=%0d got rd=%h err=%b other=%b v=%b exp rd=%h err=0 other=0 v=0", t, rd_v[w], err_v[w], rdy_v[1-w], mem_req_valid, exp_rd);
      end
      if (qrw[w]) sb_mem[qa[w]] = qd[w];
      last    = w;
      pend[w] = 1'b0;
      set_req(w, 1'b0, qa[w], qd[w], qrw[w]);
      @(negedge clk);
      checks++;
      if ({rdy_v, mem_req_valid} !== 3'b000) begin
        failures++;
        $display("FAIL rand_gap t=%0d got rdy=%b v=%b exp 0", t, rdy_v, mem_req_valid);
      end
    end
    mem_auto = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_backpressure();
    test_reset_mid_busy();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
